// File: rtl/enemy_hit_detector.sv
// Frame-synchronous hit / dodge / random-turn event generator for one enemy.
// Define ENEMY_DODGE_EN to build the dodge window logic; otherwise dodgeBullet is tied to 0.
module enemy_hit_detector #(
    parameter int          OBJECT_WIDTH_X  = 30,
    parameter int          OBJECT_HEIGHT_Y = 30,
    parameter int          DODGE_DIST      = 40,
    parameter int          RAND_MIN_FRAMES = 30,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic [10:0] pixelX,
    input  logic [10:0] pixelY,
    input  logic [10:0] enemyTopLeftX,
    input  logic [10:0] enemyTopLeftY,
    input  logic        enemyDrawingRequest,
    input  logic [2:0]  shotDrawingRequest,
    input  logic        pause,
    input  logic        respawn,
    output logic [2:0]  shotCollision,
    output logic        dodgeBullet,
    output logic        changeDirection,
    output logic        enemyDead
);

    localparam logic [0:0] ST_ALIVE = 1'b0;
    localparam logic [0:0] ST_DEAD  = 1'b1;
    localparam logic [8:0] RAND_MIN = 9'(RAND_MIN_FRAMES);

    logic [0:0]  state;
    logic [2:0]  hit_acc;
    logic [7:0]  frame_cnt;
    logic [15:0] lfsr;

    logic        active;
    logic        boundary;
    logic [2:0]  hit_sample;
    logic        hit_fire;
    logic        turn_fire;
    logic        dodge_fire;
    logic [15:0] lfsr_next;

    // enemyDead is the FSM state itself, so it doubles as the state debug view.
    assign enemyDead  = (state == ST_DEAD);
    assign active     = (state == ST_ALIVE) && !pause;
    assign boundary   = startOfFrame && !respawn;
    assign hit_sample = active ? (shotDrawingRequest & {3{enemyDrawingRequest}}) : 3'b000;
    assign hit_fire   = boundary && active && (hit_acc != 3'b000);
    assign turn_fire  = boundary && active && ({1'b0, frame_cnt} >= RAND_MIN) && (lfsr[3:0] == 4'd0);
    // Right-shifting Galois form of x^16 + x^14 + x^13 + x^11 + 1.
    assign lfsr_next  = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);

`ifdef ENEMY_DODGE_EN
    localparam logic [11:0] WIDTH_12  = 12'(OBJECT_WIDTH_X);
    localparam logic [11:0] HEIGHT_12 = 12'(OBJECT_HEIGHT_Y);
    localparam logic [11:0] DODGE_12  = 12'(DODGE_DIST);

    logic [11:0] x_lo, x_hi, y_lo, y_hi, px, py;
    logic        in_x, in_win, dodge_sample, dodge_acc;

    assign px           = {1'b0, pixelX};
    assign py           = {1'b0, pixelY};
    assign x_lo         = {1'b0, enemyTopLeftX};
    assign x_hi         = x_lo + WIDTH_12;
    assign y_lo         = {1'b0, enemyTopLeftY} + HEIGHT_12;
    assign y_hi         = y_lo + DODGE_12;
    assign in_x         = (px >= x_lo) && (px < x_hi);
    assign in_win       = (py >= y_lo) && (py < y_hi);
    assign dodge_sample = active && (|shotDrawingRequest) && in_x && in_win;
    assign dodge_fire   = boundary && active && (hit_acc == 3'b000) && dodge_acc;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            dodge_acc <= 1'b0;
        end else if (respawn || hit_fire) begin
            dodge_acc <= 1'b0;
        end else if (startOfFrame) begin
            dodge_acc <= dodge_sample;
        end else begin
            dodge_acc <= dodge_acc | dodge_sample;
        end
    end
`else
    logic unused_dodge_inputs;
    assign unused_dodge_inputs = ^{pixelX, pixelY, enemyTopLeftX, enemyTopLeftY};
    assign dodge_fire = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state           <= ST_ALIVE;
            hit_acc         <= 3'b000;
            frame_cnt       <= 8'd0;
            lfsr            <= LFSR_SEED;
            shotCollision   <= 3'b000;
            dodgeBullet     <= 1'b0;
            changeDirection <= 1'b0;
        end else begin
            shotCollision   <= 3'b000;
            dodgeBullet     <= 1'b0;
            changeDirection <= 1'b0;
            if (respawn) begin
                state     <= ST_ALIVE;
                hit_acc   <= 3'b000;
                frame_cnt <= 8'd0;
            end else if (startOfFrame) begin
                // A kill leaves the accumulators empty for the whole DEAD period.
                hit_acc     <= hit_fire ? 3'b000 : hit_sample;
                dodgeBullet <= dodge_fire;
                if (hit_fire) begin
                    shotCollision <= hit_acc;
                    state         <= ST_DEAD;
                end
                if (active) begin
                    lfsr            <= lfsr_next;
                    changeDirection <= turn_fire;
                    if (turn_fire) begin
                        frame_cnt <= 8'd0;
                    end else if (frame_cnt != 8'hFF) begin
                        frame_cnt <= frame_cnt + 8'd1;
                    end
                end
            end else begin
                hit_acc <= hit_acc | hit_sample;
            end
        end
    end

endmodule

// File: tb/tb_enemy_hit_detector.sv
// Directed plus randomized bench for enemy_hit_detector, checked against a frame-rule model.
module tb_enemy_hit_detector;

    localparam int          W    = 30;
    localparam int          H    = 30;
    localparam int          D    = 40;
    localparam int          RMIN = 30;
    localparam logic [15:0] SEED = 16'hACE1;
`ifdef ENEMY_DODGE_EN
    localparam bit DODGE_EN = 1'b1;
`else
    localparam bit DODGE_EN = 1'b0;
`endif

    logic        clk;
    logic        resetN;
    logic        startOfFrame;
    logic [10:0] pixelX, pixelY, enemyTopLeftX, enemyTopLeftY;
    logic        enemyDrawingRequest;
    logic [2:0]  shotDrawingRequest;
    logic        pause;
    logic        respawn;
    logic [2:0]  shotCollision;
    logic        dodgeBullet;
    logic        changeDirection;
    logic        enemyDead;

    enemy_hit_detector #(
        .OBJECT_WIDTH_X(W), .OBJECT_HEIGHT_Y(H), .DODGE_DIST(D),
        .RAND_MIN_FRAMES(RMIN), .LFSR_SEED(SEED)
    ) dut (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
        .pixelX(pixelX), .pixelY(pixelY),
        .enemyTopLeftX(enemyTopLeftX), .enemyTopLeftY(enemyTopLeftY),
        .enemyDrawingRequest(enemyDrawingRequest), .shotDrawingRequest(shotDrawingRequest),
        .pause(pause), .respawn(respawn),
        .shotCollision(shotCollision), .dodgeBullet(dodgeBullet),
        .changeDirection(changeDirection), .enemyDead(enemyDead)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model state
    bit        m_alive;
    bit [2:0]  m_hit;
    bit        m_dodge;
    int        m_cnt;
    bit [15:0] m_lfsr;
    int        frame_no;
    int        last_turn;
    int        n_checks;
    int        n_fail;
    int        n_turns;

    function automatic bit [15:0] lfsr_step(input bit [15:0] v);
        bit [15:0] r;
        r = v / 2;
        if (v % 2 == 1) r = r ^ 16'hB400;
        return r;
    endfunction

    function automatic bit in_dodge_window(input int x, input int y, input int ex, input int ey);
        return (x >= ex) && (x < ex + W) && (y >= ey + H) && (y < ey + H + D);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_alive   = 1'b1;
        m_hit     = 3'b000;
        m_dodge   = 1'b0;
        m_cnt     = 0;
        m_lfsr    = SEED;
        last_turn = -1;
    endtask

    // driver: one clock of pixel traffic, model update at the edge, checks 1 time unit later
    task automatic cycle(input bit sof, input int x, input int y, input bit edr,
                         input bit [2:0] sdr, input bit rsp);
        bit [2:0] sh;
        bit       sd;
        int       e_sc, e_db, e_cd;
        @(negedge clk);
        startOfFrame        = sof;
        pixelX              = 11'(x);
        pixelY              = 11'(y);
        enemyDrawingRequest = edr;
        shotDrawingRequest  = sdr;
        respawn             = rsp;
        @(posedge clk);
        sh = (m_alive && !pause && edr) ? sdr : 3'b000;
        sd = DODGE_EN && m_alive && !pause && (sdr != 0) &&
             in_dodge_window(x, y, int'(enemyTopLeftX), int'(enemyTopLeftY));
        e_sc = 0; e_db = 0; e_cd = 0;
        if (rsp) begin
            m_alive = 1'b1; m_hit = 3'b000; m_dodge = 1'b0; m_cnt = 0;
        end else if (sof) begin
            frame_no++;
            if (m_alive && !pause) begin
                if (m_hit != 0) begin
                    e_sc = int'(m_hit);
                    m_alive = 1'b0;
                end else if (m_dodge) begin
                    e_db = 1;
                end
                if (m_cnt >= RMIN && m_lfsr % 16 == 0) begin
                    e_cd = 1;
                    m_cnt = 0;
                end else if (m_cnt < 255) begin
                    m_cnt++;
                end
                m_lfsr = lfsr_step(m_lfsr);
            end
            m_hit   = m_alive ? sh : 3'b000;
            m_dodge = m_alive ? sd : 1'b0;
        end else begin
            m_hit   = m_hit | sh;
            m_dodge = m_dodge | sd;
        end
        #1;
        chk("shotCollision", 32'(shotCollision), 32'(e_sc));
        chk("dodgeBullet", 32'(dodgeBullet), 32'(e_db));
        chk("changeDirection", 32'(changeDirection), 32'(e_cd));
        chk("enemyDead", 32'(enemyDead), 32'(!m_alive));
        if (changeDirection === 1'b1) begin
            n_turns++;
            if (last_turn >= 0) chk("turn_gap_ge_min", 32'((frame_no - last_turn) >= RMIN), 32'd1);
            last_turn = frame_no;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 0, 0, 1'b0, 3'b000, 1'b0);
    endtask

    task automatic boundary();
        cycle(1'b1, 0, 0, 1'b0, 3'b000, 1'b0);
    endtask

    task automatic overlap(input bit [2:0] sdr, input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 245 + i, 205, 1'b1, sdr, 1'b0);
    endtask

    task automatic do_respawn();
        cycle(1'b0, 0, 0, 1'b0, 3'b000, 1'b1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetN = 1'b0; startOfFrame = 1'b0; respawn = 1'b0;
        enemyDrawingRequest = 1'b0; shotDrawingRequest = 3'b000;
        model_reset();
        #1;
        chk("reset_shotCollision", 32'(shotCollision), 32'd0);
        chk("reset_dodgeBullet", 32'(dodgeBullet), 32'd0);
        chk("reset_changeDirection", 32'(changeDirection), 32'd0);
        chk("reset_enemyDead", 32'(enemyDead), 32'd0);
        repeat (2) @(negedge clk);
        resetN = 1'b1;
    endtask

    initial begin
        n_checks = 0; n_fail = 0; frame_no = 0; n_turns = 0;
        resetN = 1'b0; startOfFrame = 1'b0; pause = 1'b0; respawn = 1'b0;
        pixelX = '0; pixelY = '0; enemyDrawingRequest = 1'b0; shotDrawingRequest = 3'b000;
        enemyTopLeftX = 11'd240; enemyTopLeftY = 11'd200;
        model_reset();
        repeat (2) @(posedge clk);
        do_reset();

        // hit: shot 1 overlaps for 5 pixels, then a frame of further overlaps while dead
        boundary();
        idle(2); overlap(3'b010, 5); idle(2);
        boundary();
        overlap(3'b010, 5);
        boundary();

        // respawn, then a multi-shot hit reports every overlapping shot together
        do_respawn();
        boundary();
        overlap(3'b001, 2); overlap(3'b100, 2);
        boundary();
        do_respawn();

        // dodge inside the window, then just past its last row, then hit + dodge together
        boundary();
        cycle(1'b0, 250, 235, 1'b0, 3'b001, 1'b0);
        boundary();
        cycle(1'b0, 250, 270, 1'b0, 3'b001, 1'b0);
        boundary();
        cycle(1'b0, 250, 269, 1'b0, 3'b100, 1'b0);
        overlap(3'b001, 3);
        boundary();
        do_respawn();

        // pause across a whole frame containing an overlap
        pause = 1'b1;
        boundary();
        overlap(3'b011, 5);
        boundary();
        pause = 1'b0;
        idle(2);
        boundary();

        // respawn coinciding with the boundary suppresses events
        overlap(3'b100, 3);
        cycle(1'b1, 0, 0, 1'b0, 3'b000, 1'b1);
        idle(1);
        boundary();

        // back-to-back boundaries: the second sees only the first one's own sample
        overlap(3'b001, 2);
        cycle(1'b1, 246, 205, 1'b1, 3'b100, 1'b0);
        boundary();
        do_respawn();

        // reset mid-frame after an overlap discards it
        boundary();
        overlap(3'b010, 4);
        do_reset();
        idle(2);
        boundary();

        // 200 boundaries, no hits, random shots around the dodge window
        for (int f = 0; f < 200; f++) begin
            for (int i = 0; i < 3; i++)
                cycle(1'b0, 230 + $urandom_range(0, 50), 220 + $urandom_range(0, 60),
                      1'b0, 3'($urandom_range(0, 7)), 1'b0);
            boundary();
        end

        // fully random traffic: hits, pause, respawn and boundaries in any combination
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 19) == 0) pause = ~pause;
            cycle($urandom_range(0, 5) == 0,
                  230 + $urandom_range(0, 50), 195 + $urandom_range(0, 85),
                  $urandom_range(0, 9) == 0, 3'($urandom_range(0, 7)),
                  $urandom_range(0, 39) == 0);
        end
        pause = 1'b0;
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/enemy_hit_detector.md
# enemy_hit_detector

Per-frame event generator feeding the enemy motion stage. It accumulates pixel-level overlaps between the enemy's drawing request and up to three shot drawing requests, and reports hits on `shotCollision`. It detects shots approaching from below the enemy and raises `dodgeBullet`. It issues pseudo-random `changeDirection` pulses from an LFSR. It sits between the VGA object drawers (enemy, shots) and the enemy move/collision block, and all of its outputs are frame-synchronous pulses.

## Interface
Parameters:
- `OBJECT_WIDTH_X`, 30, enemy width in pixels (must match the enemy motion stage).
- `OBJECT_HEIGHT_Y`, 30, enemy height in pixels.
- `DODGE_DIST`, 40, height in rows of the dodge window directly below the enemy.
- `RAND_MIN_FRAMES`, 30, minimum number of frames between `changeDirection` pulses.
- `LFSR_SEED`, 16'hACE1, LFSR reset value; must be non-zero.

Ports:
- `clk` in 1: system clock.
- `resetN` in 1: reset. One clock; reset is asynchronous and active-low.
- `startOfFrame` in 1: one-cycle frame strobe.
- `pixelX`, `pixelY` in 11 each: current VGA pixel.
- `enemyTopLeftX`, `enemyTopLeftY` in 11 each: enemy position from the motion stage.
- `enemyDrawingRequest` in 1: enemy pixel is active.
- `shotDrawingRequest` in 3: bit i means shot i's pixel is active.
- `pause` in 1: freezes event generation.
- `respawn` in 1: one-cycle request to revive a dead enemy.
- `shotCollision` out 3: one-cycle hit pulse; bit i identifies the shot that hit.
- `dodgeBullet` out 1: one-cycle dodge pulse.
- `changeDirection` out 1: one-cycle random turn pulse.
- `enemyDead` out 1: level, high while the FSM is in DEAD.

## Operation
- FSM states and transitions:
  - ALIVE goes to DEAD on a frame boundary where `hitAcc != 0`.
  - DEAD goes to ALIVE on `respawn`.
  - No other transitions.
- Accumulators (ALIVE and `!pause` only) are sticky ORs over the frame:
  - `hitAcc[i] |= enemyDrawingRequest & shotDrawingRequest[i]`.
  - `dodgeAcc |= (|shotDrawingRequest) & inX & inWin`.
  - `inX` = `pixelX` in [`enemyTopLeftX`, `enemyTopLeftX+OBJECT_WIDTH_X`).
  - `inWin` = `pixelY` in [`enemyTopLeftY+OBJECT_HEIGHT_Y`, `enemyTopLeftY+OBJECT_HEIGHT_Y+DODGE_DIST`).
  - All bounds are computed 12-bit unsigned, with no wrap.
- Frame boundary (the cycle with `startOfFrame=1`):
  - The accumulators are loaded with that cycle's own sample, not the OR with the old value.
  - Event decisions use the pre-boundary accumulator values.
- Hit: if ALIVE and `hitAcc != 0`:
  - `shotCollision <= hitAcc` for one cycle; all set bits are reported together.
  - The FSM moves to DEAD and `enemyDead` goes to 1.
- Dodge: if ALIVE, `!pause`, `dodgeAcc=1` and no hit this boundary, `dodgeBullet` pulses.
  - A hit and a dodge in the same frame produce the hit only.
- Random turn:
  - A 16-bit Galois LFSR (taps 16,14,13,11) and an 8-bit `frameCnt` (saturating at 255) advance on each boundary while ALIVE and `!pause`.
  - If `frameCnt >= RAND_MIN_FRAMES` and `lfsr[3:0]==0` (values before the advance), `changeDirection` pulses and `frameCnt` is cleared to 0.
- Pause:
  - No accumulation and no pulses; LFSR and `frameCnt` hold.
  - The boundary still loads accumulators, with a zero sample.
- DEAD: accumulators are held at 0, no pulses, LFSR and `frameCnt` hold.
- `respawn` (any cycle):
  - Sets the FSM to ALIVE, clears the accumulators and `frameCnt`.
  - The LFSR is untouched.
  - `respawn` coinciding with `startOfFrame` takes priority: no events are issued at that boundary.

## Timing
- Reset values:
  - `shotCollision=0`, `dodgeBullet=0`, `changeDirection=0`, `enemyDead=0`.
  - FSM=ALIVE, accumulators=0, `frameCnt=0`, `lfsr=LFSR_SEED`.
- All outputs are registered.
- Pulses are high for exactly the one cycle after the clock edge that samples `startOfFrame=1`. Latency from the boundary is 1 cycle; latency from the offending pixel is at most 1 frame.
- `enemyDead` rises in the same cycle as the `shotCollision` pulse.
- `enemyDead` falls the cycle after `respawn` is sampled.
- Reset asserted mid-frame discards the partial accumulation; no pulse follows deassertion until the next boundary.
- Two consecutive `startOfFrame` cycles: each is a boundary; the second sees accumulators holding a single sample.

## Configuration
- `ENEMY_DODGE_EN` defined: dodge window logic and `dodgeAcc` are built as described above.
- `ENEMY_DODGE_EN` undefined: no dodge logic is synthesised and `dodgeBullet` is tied to 0. Hit and random-turn behaviour is unchanged.

## Test plan
- Hit:
  - Stimulus: enemy at (240,200); `shotDrawingRequest=3'b010` overlapping `enemyDrawingRequest` for 5 pixels mid-frame; then `startOfFrame`.
  - Required response: `shotCollision=3'b010` for 1 cycle, `enemyDead=1`. With further overlaps in the next frame, `shotCollision` stays 0.
- Dodge:
  - Stimulus: enemy at (240,200); shot pixel at (250,235); then `startOfFrame`. Repeat with the shot at (250,270).
  - Required response: (250,235) gives a `dodgeBullet` pulse. (250,270) gives none (outside the window, which ends at row 269). With `ENEMY_DODGE_EN` undefined, no pulse in either case.
- Hit and dodge in the same frame:
  - Stimulus: both a hit overlap and a dodge-window shot pixel in one frame.
  - Required response: only `shotCollision` pulses; `dodgeBullet=0`.
- Random turn:
  - Stimulus: seed 16'hACE1, 200 boundaries with `pause=0`.
  - Required response: `changeDirection` pulse frames match a reference LFSR model; gaps between pulses are all ≥30 frames.
- Pause:
  - Stimulus: `pause=1` across a frame containing a hit overlap.
  - Required response: no pulse at the boundary, LFSR value unchanged, `enemyDead=0`.
- Respawn and reset:
  - Stimulus: `respawn` while DEAD.
  - Required response: `enemyDead` goes to 0 the next cycle and a new hit is reported. Reset asserted mid-frame after an overlap gives no pulse at the following boundary.
